sync_dualrail_source_2bits: RTL

Clocked-to-asynchronous bridge that feeds the head of the 2-bit dual-rail asynchronous pipeline. It accepts 2-bit words from the synchronous domain through a valid/ready port and buffers them in a small FIFO. Each word is driven onto the 4-wire dual-rail bus with a four-phase (return-to-zero) handshake against the first asynchronous buffer stage's ack. The ack is resynchronised internally, so the asynchronous stage needs no knowledge of the clock.

---
 rtl/sync_dualrail_source_2bits.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sync_dualrail_source_2bits.sv
// Synchronous-to-asynchronous bridge: buffers 2-bit words from a valid/ready port
// and emits them as dual-rail codewords with a four-phase handshake on ack_in.
module sync_dualrail_source_2bits #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  data_out,
  input  logic        ack_in,
  output logic        busy,
  output logic [15:0] tx_count,
  output logic        proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [1:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   full, push, pop;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s, ack_s_d, ack_rise;
  logic [3:0]             data_next;
  logic                   tx_inc;

  function automatic logic [3:0] encode(input logic [1:0] d);
    return {d[1], ~d[1], d[0], ~d[0]};
  endfunction

  // Handshake: a word is accepted on any rising edge where in_valid and in_ready
  // are both high; in_ready depends only on the registered fill level.
  assign full     = (count == CW'(FIFO_DEPTH));
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign busy     = (count != '0) | (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // ack_in is asynchronous to clk; only the resynchronised ack_s reaches the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      ack_s_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ack_in};
      ack_s_d <= ack_s;
    end
  end

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign ack_rise = ack_s & ~ack_s_d;

  always_comb begin
    state_next = state;
    data_next  = data_out;
    pop        = 1'b0;
    tx_inc     = 1'b0;
    case (state)
      IDLE: begin
        // A still-high ack (e.g. stale across reset) blocks emission until it drops.
        if (count != '0 && !ack_s) begin
          pop        = 1'b1;
          data_next  = encode(mem[rd_ptr]);
          state_next = WAIT_HI;
        end else begin
          data_next = 4'b0000;
        end
      end
      WAIT_HI: begin
        if (ack_s) begin
          data_next  = 4'b0000;
          tx_inc     = 1'b1;
          state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ack_s) state_next = IDLE;
      end
      default: begin
        data_next  = 4'b0000;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_out  <= 4'b0000;
      tx_count  <= 16'd0;
      proto_err <= 1'b0;
    end else begin
      state    <= state_next;
      data_out <= data_next;
      if (tx_inc) tx_count <= tx_count + 16'd1;
      if (ack_rise && (state == IDLE || state == WAIT_LO)) proto_err <= 1'b1;
    end
  end

endmodule
